// File: rtl/jtag_gpio_arbiter.sv
// Arbitrates the GPIO output/enable register bank between the JTAG path and
// NR_REQ local requesters; each grant does a masked write, settles, samples pads, acks.
module jtag_gpio_arbiter #(
  parameter int unsigned NR_GPIOS      = 3,
  parameter int unsigned NR_REQ        = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             jtag_req,
  input  logic [NR_GPIOS-1:0]              jtag_wr_out,
  input  logic [NR_GPIOS-1:0]              jtag_wr_oe,
  input  logic [NR_GPIOS-1:0]              jtag_mask,
  output logic                             jtag_ack,
  input  logic [NR_REQ-1:0]                req,
  input  logic [NR_REQ*NR_GPIOS-1:0]       wr_out,
  input  logic [NR_REQ*NR_GPIOS-1:0]       wr_oe,
  input  logic [NR_REQ*NR_GPIOS-1:0]       mask,
  output logic [NR_REQ-1:0]                ack,
  output logic [NR_GPIOS-1:0]              rd_data,
  input  logic [NR_GPIOS-1:0]              gpio_inputs,
  output logic [NR_GPIOS-1:0]              gpio_outputs,
  output logic [NR_GPIOS-1:0]              gpio_outputs_ena,
  output logic                             busy,
  output logic [$clog2(NR_REQ+1)-1:0]      grant_id
);

  localparam int unsigned GW = $clog2(NR_REQ + 1);
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, ACK} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [NR_GPIOS-1:0] out_q, out_d;
  logic [NR_GPIOS-1:0] oe_q, oe_d;
  logic [NR_GPIOS-1:0] rd_q, rd_d;
  logic                busy_q, busy_d;
  logic                jack_q, jack_d;
  logic [NR_REQ-1:0]   ack_q, ack_d;

  logic                found;
  logic [PW-1:0]       win;
  logic [PW-1:0]       idx;
  logic [31:0]         sum;
  logic [NR_GPIOS-1:0] w_out, w_oe, w_mask;

  // Round-robin search over local requests, starting at the pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    sum   = '0;
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      sum = 32'(ptr_q) + k;
      if (sum >= NR_REQ) sum = sum - NR_REQ;
      idx = PW'(sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Winner's write payload; JTAG has strict priority
  always_comb begin
    w_out  = '0;
    w_oe   = '0;
    w_mask = '0;
    if (jtag_req) begin
      w_out  = jtag_wr_out;
      w_oe   = jtag_wr_oe;
      w_mask = jtag_mask;
    end else begin
      for (int unsigned i = 0; i < NR_REQ; i++) begin
        if (found && (win == PW'(i))) begin
          w_out  = wr_out[i*NR_GPIOS +: NR_GPIOS];
          w_oe   = wr_oe[i*NR_GPIOS +: NR_GPIOS];
          w_mask = mask[i*NR_GPIOS +: NR_GPIOS];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    out_d   = out_q;
    oe_d    = oe_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    jack_d  = 1'b0;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (jtag_req || found) begin
          out_d   = (out_q & ~w_mask) | (w_out & w_mask);
          oe_d    = (oe_q & ~w_mask) | (w_oe & w_mask);
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          busy_d  = 1'b1;
          state_d = SETTLE;
          if (jtag_req) begin
            grant_d = GW'(NR_REQ);
          end else begin
            grant_d = GW'(win);
            if (32'(win) == NR_REQ - 1) ptr_d = '0;
            else                        ptr_d = win + PW'(1);
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          rd_d    = gpio_inputs;
          state_d = ACK;
          jack_d  = (grant_q == GW'(NR_REQ));
          for (int unsigned i = 0; i < NR_REQ; i++) begin
            if (grant_q == GW'(i)) ack_d[i] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      out_q   <= '0;
      oe_q    <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      jack_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      jack_q  <= jack_d;
      ack_q   <= ack_d;
    end
  end

  assign gpio_outputs     = out_q;
  assign gpio_outputs_ena = oe_q;
  assign rd_data          = rd_q;
  assign busy             = busy_q;
  assign grant_id         = grant_q;
  assign jtag_ack         = jack_q;
  assign ack              = ack_q;

endmodule

// File: doc/jtag_gpio_arbiter.md
Name: jtag_gpio_arbiter

Overview:
- Shares the GPIO output/output-enable register bank between the JTAG GPIO path and NR_REQ local fabric requesters. All requesters reach it through one request/ack handshake.
- Each granted transaction performs a masked write to the outputs and enables, waits SETTLE_CYCLES for the pads to settle, samples gpio_inputs as readback, then acks.
- It sits between jtag_gpios (or its clk-domain synchronizer) plus local logic on one side, and the tristate pad drivers in top on the other.

Parameters:
- NR_GPIOS, 3: number of GPIO pins.
- NR_REQ, 2: number of local requesters (at least 1).
- SETTLE_CYCLES, 4: cycles between the output update and the input sample (at least 1).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- jtag_req  in  1  JTAG-side request; held until jtag_ack.
- jtag_wr_out  in  NR_GPIOS  output values to write.
- jtag_wr_oe  in  NR_GPIOS  output-enable values to write.
- jtag_mask  in  NR_GPIOS  per-bit write mask (1 = update this bit).
- jtag_ack  out  1  one-cycle completion pulse.
- req  in  NR_REQ  local requests; bit i belongs to requester i.
- wr_out  in  NR_REQ*NR_GPIOS  local output values; slice i is [i*NR_GPIOS +: NR_GPIOS].
- wr_oe  in  NR_REQ*NR_GPIOS  local enable values, same slicing as wr_out.
- mask  in  NR_REQ*NR_GPIOS  local write masks, same slicing as wr_out.
- ack  out  NR_REQ  one-cycle completion pulses, one per requester.
- rd_data  out  NR_GPIOS  gpio_inputs sampled at the end of the last transaction.
- gpio_inputs  in  NR_GPIOS  pad input values.
- gpio_outputs  out  NR_GPIOS  registered output values.
- gpio_outputs_ena  out  NR_GPIOS  registered output enables.
- busy  out  1  high while a transaction is in progress.
- grant_id  out  $clog2(NR_REQ+1)  current owner: 0..NR_REQ-1 for local requesters, NR_REQ for JTAG; valid only while busy.

Behaviour:
- Reset (synchronous, overrides everything):
  - gpio_outputs=0, gpio_outputs_ena=0 (all pads tristate), rd_data=0.
  - jtag_ack=0, ack=0, busy=0, grant_id=0, state=IDLE.
  - Round-robin pointer gives priority to requester 0.
  - Reset mid-transaction aborts it with no ack issued.
- FSM states: IDLE, SETTLE, ACK.
- IDLE, arbitration:
  - If jtag_req is high, JTAG wins (strict priority).
  - Otherwise the first asserted req[i] wins, searching from the pointer upward with wrap-around.
  - No request: stay in IDLE, busy=0.
- IDLE, on grant (decision cycle = cycle 0):
  - At the end of cycle 0: gpio_outputs <= (gpio_outputs & ~m) | (w_out & m), and gpio_outputs_ena <= (gpio_outputs_ena & ~m) | (w_oe & m), using the winner's data and mask.
  - Latch grant_id, load the settle counter, go to SETTLE.
  - The new pin values are visible from cycle 1.
- Round-robin pointer:
  - Updates only on a local grant, to the winner + 1 modulo NR_REQ.
  - JTAG grants leave it unchanged.
- SETTLE:
  - busy=1 for exactly SETTLE_CYCLES cycles (cycles 1..SETTLE_CYCLES).
  - In the final SETTLE cycle, rd_data <= gpio_inputs; then go to ACK.
- ACK (cycle SETTLE_CYCLES+1):
  - busy=1; the granted requester's ack/jtag_ack is high for this single cycle; rd_data is valid.
  - Next state is IDLE.
  - Total request-to-ack latency is SETTLE_CYCLES+1 cycles; with the default, req seen in cycle 0 gives ack in cycle 5.
- Handshake rules:
  - Requesters hold req and data stable until ack.
  - Data and mask are sampled only in the grant cycle; changes afterwards are ignored.
  - A req that drops while busy does not cancel the transaction; it still completes and acks.
  - A req still high in the IDLE cycle after its ack is treated as a new request.
  - Back-to-back transactions cost 1 idle cycle each (the IDLE arbitration cycle).
- Boundary cases:
  - mask=0: full sequence still runs, registers are unchanged, ack is issued, rd_data is refreshed.
  - Simultaneous jtag_req and local req: JTAG wins; the local requester waits, and its pointer position is kept.
  - Continuous jtag_req starves local requesters; this is intended (debug override).
- The settle counter width is $clog2(SETTLE_CYCLES+1) and wraps nowhere: it loads SETTLE_CYCLES-1 and counts down to 0.
- No outputs change outside the grant cycle (registers) or the ACK cycle (rd_data, acks).

Test Plan:
- Reset, then idle 10 cycles: gpio_outputs=000, gpio_outputs_ena=000, busy=0, no acks, rd_data=000.
- req[0] with wr_out=101, wr_oe=111, mask=111 in cycle 0: outputs=101 and ena=111 from cycle 1; ack[0] high only in cycle 5; rd_data equals gpio_inputs sampled in cycle 4; grant_id=0 in cycles 1-5.
- req[0] and req[1] held continuously, each dropped the cycle after its ack: grants alternate 0,1,0,1; each ack is 6 cycles after the prior ack; exactly one ack per transaction.
- jtag_req and req[1] asserted together with jtag_mask=010, jtag_wr_out=010, prior outputs=101: JTAG served first, outputs become 111 and only bit 1 changes; jtag_ack in cycle 5; req[1] granted in cycle 6 with grant_id=1.
- Local write with mask=000: outputs unchanged, ack still in cycle 5.
- Reset asserted in cycle 3 of a transaction: no ack, state IDLE, outputs=000 and ena=000 next cycle; a request held through reset is re-granted after reset deasserts.
